// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 16-bit 5-stage core.
// Tracks destinations of the instructions in EX and DM, registers the
// per-port bypass selects, and raises load-use interlock, bubble and flush.
module hazard_ctrl #(
  parameter int RF_AW = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RF_AW-1:0] p0_addr_ID,
  input  logic [RF_AW-1:0] p1_addr_ID,
  input  logic             re0_ID,
  input  logic             re1_ID,
  input  logic [RF_AW-1:0] dst_addr_ID,
  input  logic             we_rf_ID,
  input  logic             ld_ID,
  input  logic             flow_change_ID_EX,
  input  logic             mem_stall,
  output logic             byp0_EX,
  output logic             byp0_DM,
  output logic             byp1_EX,
  output logic             byp1_DM,
  output logic             stall_IM_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_DM,
  output logic             bubble_ID_EX,
  output logic             flush_IF_ID,
  output logic [CNT_W-1:0] stall_cnt
);

  // Shadow of the instruction in EX and in DM
  logic [RF_AW-1:0] dst_ID_EX;
  logic             we_ID_EX;
  logic             ld_ID_EX;
  logic [RF_AW-1:0] dst_EX_DM;
  logic             we_EX_DM;

  logic hit_ex0, hit_ex1, hit_dm0, hit_dm1;
  logic lu;

  // Source-operand match against the EX and DM producers (R0 never matches)
  always_comb begin
    hit_ex0 = re0_ID & we_ID_EX & (p0_addr_ID == dst_ID_EX) & (p0_addr_ID != '0);
    hit_ex1 = re1_ID & we_ID_EX & (p1_addr_ID == dst_ID_EX) & (p1_addr_ID != '0);
    hit_dm0 = re0_ID & we_EX_DM & (p0_addr_ID == dst_EX_DM) & (p0_addr_ID != '0);
    hit_dm1 = re1_ID & we_EX_DM & (p1_addr_ID == dst_EX_DM) & (p1_addr_ID != '0);
    lu      = ld_ID_EX & (hit_ex0 | hit_ex1);
  end

  // Prioritised pipeline controls: memory stall, then flush, then load-use
  always_comb begin
    stall_IM_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    bubble_ID_EX = 1'b0;
    flush_IF_ID  = 1'b0;
    if (mem_stall) begin
      stall_IM_ID = 1'b1;
      stall_ID_EX = 1'b1;
      stall_EX_DM = 1'b1;
    end else if (flow_change_ID_EX) begin
      flush_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end else if (lu) begin
      stall_IM_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end
  end

  // Advance the EX/DM shadows and register bypass selects; frozen on mem_stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_ID_EX <= '0;
      we_ID_EX  <= 1'b0;
      ld_ID_EX  <= 1'b0;
      dst_EX_DM <= '0;
      we_EX_DM  <= 1'b0;
      byp0_EX   <= 1'b0;
      byp0_DM   <= 1'b0;
      byp1_EX   <= 1'b0;
      byp1_DM   <= 1'b0;
    end else if (!mem_stall) begin
      dst_EX_DM <= dst_ID_EX;
      we_EX_DM  <= we_ID_EX;
      if (bubble_ID_EX) begin
        dst_ID_EX <= '0;
        we_ID_EX  <= 1'b0;
        ld_ID_EX  <= 1'b0;
        byp0_EX   <= 1'b0;
        byp0_DM   <= 1'b0;
        byp1_EX   <= 1'b0;
        byp1_DM   <= 1'b0;
      end else begin
        dst_ID_EX <= dst_addr_ID;
        we_ID_EX  <= we_rf_ID;
        ld_ID_EX  <= ld_ID;
        byp0_EX   <= hit_ex0;
        byp0_DM   <= hit_dm0 & ~hit_ex0;
        byp1_EX   <= hit_ex1;
        byp1_DM   <= hit_dm1 & ~hit_ex1;
      end
    end
  end

  // Saturating count of load-use stall cycles; the counter is frozen
  // together with the rest of the state while mem_stall holds the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!mem_stall && stall_IM_ID && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
